mdio_master_seq: RTL and testbench

Clause 45 MDIO management-frame sequencer (station-management side) used as a bench and bring-up master for the MDIO slave block. It also serves as the on-chip master when the die manages an external PHY. The block accepts one command at a time over a valid/ready handshake, derives MDC from PCLK, and serialises the frame: preamble, ST, OP, PRTAD, DEVAD, TA, DATA. It returns read data and a turnaround-error flag with a one-cycle response pulse.

---
 rtl/mdio_master_seq_if.sv | 26 ++
 rtl/mdio_master_seq.sv | 181 ++++++++++++++++++
 tb/tb_mdio_master_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_master_seq_if.sv
// Command/response bundle for the Clause 45 MDIO master sequencer.
//   cmd_valid/cmd_ready : one-command-at-a-time handshake
//   cmd_op/prtad/devad/data : frame fields, sampled only on the accept cycle
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion pulse, read data, TA error
// master modport: the command issuer; slave modport: the sequencer.
interface mdio_master_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_prtad;
  logic [4:0]  cmd_devad;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_prtad, cmd_devad, cmd_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_prtad, cmd_devad, cmd_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mdio_master_seq.sv
// Clause 45 MDIO station-management frame sequencer.
// Accepts one command over bus (slave modport), derives MDC from PCLK and
// serialises preamble, ST, OP, PRTAD, DEVAD, TA, DATA; returns read data and
// a turnaround-error flag with a one-cycle rsp_valid pulse.
// Ports:
//   PCLK, PRESETn : clock, synchronous active-low reset
//   bus           : command/response handshake bundle
//   busy          : frame in progress (cmd_ready is its complement)
//   MDC           : management clock, PCLK/(2*DIV)
//   MDIO_out/mdio_oe : serial data out and its pad enable
//   MDIO_in       : serial data in, already synchronised to PCLK
module mdio_master_seq #(
  parameter int unsigned DIV     = 2,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  mdio_master_seq_if.slave  bus,
  output logic              busy,
  output logic              MDC,
  output logic              MDIO_out,
  output logic              mdio_oe,
  input  logic              MDIO_in
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned N     = PRE_LEN + 32;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   PRE_W    = (IDX_W + 1)'(PRE_LEN);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t           state;
  logic [CNT_W-1:0] div_cnt;
  logic [IDX_W-1:0] bit_idx;
  logic [1:0]       op_q;
  logic [4:0]       prtad_q;
  logic [4:0]       devad_q;
  logic [15:0]      data_q;
  logic [15:0]      rd_sh;
  logic             ta_err;

  logic             sample_c;
  logic [IDX_W:0]   rel_c;
  logic [15:0]      rd_next_c;

  // {oe, value} for frame bit idx. Position is taken relative to the end of
  // the preamble; a negative offset (MSB set) means a preamble bit.
  // Read-type opcodes (op[1]=1) release the line from the first TA bit on.
  function automatic logic [1:0] frame_bit(
    input logic [IDX_W-1:0] idx,
    input logic [1:0]       op,
    input logic [4:0]       prtad,
    input logic [4:0]       devad,
    input logic [15:0]      data
  );
    logic [IDX_W:0]   rel;
    logic [IDX_W-1:0] r;
    logic             oe;
    logic             val;
    rel = {1'b0, idx} - PRE_W;
    r   = rel[IDX_W-1:0];
    oe  = 1'b1;
    val = 1'b1;
    if (!rel[IDX_W]) begin
      if (r < 6'd2)       val = 1'b0;
      else if (r < 6'd4)  val = op[~r[0]];
      else if (r < 6'd9)  val = prtad[3'(6'd8 - r)];
      else if (r < 6'd14) val = devad[3'(6'd13 - r)];
      else if (op[1]) begin
        oe  = 1'b0;
        val = 1'b1;
      end
      else if (r == 6'd14) val = 1'b1;
      else if (r == 6'd15) val = 1'b0;
      else                 val = data[4'(6'd31 - r)];
    end
    return {oe, val};
  endfunction

  // Read shift register value including this cycle's sample, so the last
  // data bit is captured even when the sample and frame end coincide (DIV=1).
  always_comb begin
    sample_c  = (state == HIGH) && (div_cnt == '0);
    rel_c     = {1'b0, bit_idx} - PRE_W;
    rd_next_c = rd_sh;
    if (sample_c && !rel_c[IDX_W] && (rel_c[IDX_W-1:0] >= 6'd16))
      rd_next_c = {rd_sh[14:0], MDIO_in};
  end

  // Sequencer: bit timing, serialisation, sampling and response.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_idx       <= '0;
      op_q          <= '0;
      prtad_q       <= '0;
      devad_q       <= '0;
      data_q        <= '0;
      rd_sh         <= '0;
      ta_err        <= 1'b0;
      busy          <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      MDC           <= 1'b0;
      MDIO_out      <= 1'b1;
      mdio_oe       <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      rd_sh         <= rd_next_c;
      if (sample_c && !rel_c[IDX_W] && (rel_c[IDX_W-1:0] == 6'd15))
        ta_err <= MDIO_in;

      case (state)
        IDLE: begin
          if (bus.cmd_valid && bus.cmd_ready) begin
            op_q                <= bus.cmd_op;
            prtad_q             <= bus.cmd_prtad;
            devad_q             <= bus.cmd_devad;
            data_q              <= bus.cmd_data;
            state               <= LOW;
            div_cnt             <= '0;
            bit_idx             <= '0;
            busy                <= 1'b1;
            bus.cmd_ready       <= 1'b0;
            MDC                 <= 1'b0;
            {mdio_oe, MDIO_out} <= frame_bit(IDX_W'(0), bus.cmd_op, bus.cmd_prtad,
                                             bus.cmd_devad, bus.cmd_data);
          end
        end

        LOW: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            state   <= HIGH;
            MDC     <= 1'b1;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        HIGH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            MDC     <= 1'b0;
            if (bit_idx == IDX_LAST) begin
              state         <= IDLE;
              busy          <= 1'b0;
              bus.cmd_ready <= 1'b1;
              bus.rsp_valid <= 1'b1;
              MDIO_out      <= 1'b1;
              mdio_oe       <= 1'b0;
              if (op_q[1]) begin
                bus.rsp_rdata <= rd_next_c;
                bus.rsp_err   <= ta_err;
              end else begin
                bus.rsp_err   <= 1'b0;
              end
            end else begin
              state               <= LOW;
              bit_idx             <= bit_idx + IDX_W'(1);
              {mdio_oe, MDIO_out} <= frame_bit(bit_idx + IDX_W'(1), op_q, prtad_q,
                                               devad_q, data_q);
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_master_seq.sv
// Directed bench for mdio_master_seq: a default instance (PRE_LEN=32, DIV=2)
// and a short-frame instance (PRE_LEN=0, DIV=1). Frames come from a vector
// table with hand-computed post-preamble bit patterns; reset-abort and reset
// values are hand-written sequences.
module tb_mdio_master_seq;

  localparam int unsigned P0 = 32;
  localparam int unsigned D0 = 2;
  localparam int unsigned P1 = 0;
  localparam int unsigned D1 = 1;
  localparam int unsigned NV = 8;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  logic MDIO_in = 1'b1;
  logic sel     = 1'b0;

  mdio_master_seq_if bus0 ();
  mdio_master_seq_if bus1 ();

  logic busy0, mdc0, out0, oe0;
  logic busy1, mdc1, out1, oe1;

  mdio_master_seq #(.DIV(D0), .PRE_LEN(P0)) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus0), .busy(busy0),
    .MDC(mdc0), .MDIO_out(out0), .mdio_oe(oe0), .MDIO_in(MDIO_in)
  );

  mdio_master_seq #(.DIV(D1), .PRE_LEN(P1)) dut1 (
    .PCLK(PCLK), .PRESETn(PRESETn), .bus(bus1), .busy(busy1),
    .MDC(mdc1), .MDIO_out(out1), .mdio_oe(oe1), .MDIO_in(MDIO_in)
  );

  always #5 PCLK = ~PCLK;

  int edge_cnt = 0;
  always @(posedge PCLK) edge_cnt <= edge_cnt + 1;

  wire        o_ready = sel ? bus1.cmd_ready : bus0.cmd_ready;
  wire        o_rv    = sel ? bus1.rsp_valid : bus0.rsp_valid;
  wire [15:0] o_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  wire        o_err   = sel ? bus1.rsp_err   : bus0.rsp_err;
  wire        o_busy  = sel ? busy1 : busy0;
  wire        o_mdc   = sel ? mdc1  : mdc0;
  wire        o_out   = sel ? out1  : out0;
  wire        o_oe    = sel ? oe1   : oe0;

  typedef struct {
    logic        sel;
    logic [1:0]  op;
    logic [4:0]  prtad;
    logic [4:0]  devad;
    logic [15:0] data;
    logic        phy;
    logic [15:0] phy_data;
    logic [31:0] exp_frame;
    logic [31:0] exp_oe;
    logic [15:0] exp_rdata;
    logic        exp_err;
    logic        hold;
  } vec_t;

  vec_t vecs [NV];
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   prev_acc = 0;

  function automatic vec_t mk(input logic s, input logic [1:0] op, input logic [4:0] pa,
                              input logic [4:0] da, input logic [15:0] d, input logic phy,
                              input logic [15:0] pd, input logic [31:0] ef, input logic [31:0] eo,
                              input logic [15:0] er, input logic ee, input logic h);
    vec_t v;
    v.sel = s; v.op = op; v.prtad = pa; v.devad = da; v.data = d; v.phy = phy;
    v.phy_data = pd; v.exp_frame = ef; v.exp_oe = eo; v.exp_rdata = er;
    v.exp_err = ee; v.hold = h;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_cmd(input logic v, input logic [1:0] op, input logic [4:0] pa,
                         input logic [4:0] da, input logic [15:0] d);
    bus0.cmd_valid = v && !sel;
    bus1.cmd_valid = v && sel;
    bus0.cmd_op = op; bus0.cmd_prtad = pa; bus0.cmd_devad = da; bus0.cmd_data = d;
    bus1.cmd_op = op; bus1.cmd_prtad = pa; bus1.cmd_devad = da; bus1.cmd_data = d;
  endtask

  // PHY model: releases the line (reads 1) except TA bit 2 and data when present.
  function automatic logic phy_bit(input vec_t v, input int rel);
    if (!v.phy || rel < 15) return 1'b1;
    if (rel == 15) return 1'b0;
    return v.phy_data[31 - rel];
  endfunction

  // Entered at a negedge with the command already presented; returns at the
  // negedge of the response cycle.
  task automatic run_frame(input vec_t v, input vec_t nxt, output int acc);
    int pl, dv, f, k, ph;
    int mdc_bad, busy_bad, rv_bad, rdy_bad;
    logic [63:0] ob, eb;
    logic [31:0] post, poe;
    logic pre_ok;
    pl = v.sel ? int'(P1) : int'(P0);
    dv = v.sel ? int'(D1) : int'(D0);
    f  = (pl + 32) * 2 * dv;
    mdc_bad = 0; busy_bad = 0; rv_bad = 0; rdy_bad = 0;
    ob = '0; eb = '0;
    check("ready_before_accept", 64'(o_ready), 64'd1);
    @(posedge PCLK);
    #1;
    acc = edge_cnt;
    set_cmd(v.hold, ~v.op, ~v.prtad, ~v.devad, ~v.data);
    for (int c = 1; c <= f; c++) begin
      @(negedge PCLK);
      k  = (c - 1) / (2 * dv);
      ph = (c - 1) % (2 * dv);
      MDIO_in = phy_bit(v, k - pl);
      if (ph == 0) begin
        ob[k] = o_out;
        eb[k] = o_oe;
      end
      if (o_mdc !== (ph >= dv)) mdc_bad++;
      if (o_busy !== 1'b1)      busy_bad++;
      if (o_rv !== 1'b0)        rv_bad++;
      if (o_ready !== 1'b0)     rdy_bad++;
    end
    @(negedge PCLK);
    MDIO_in = 1'b1;
    for (int j = 0; j < 32; j++) begin
      post[31 - j] = ob[pl + j];
      poe[31 - j]  = eb[pl + j];
    end
    if (pl > 0) begin
      pre_ok = 1'b1;
      for (int j = 0; j < pl; j++) if (!ob[j] || !eb[j]) pre_ok = 1'b0;
      check("preamble_ones", 64'(pre_ok), 64'd1);
    end
    check("frame_bits", 64'(post), 64'(v.exp_frame));
    check("frame_oe", 64'(poe), 64'(v.exp_oe));
    check("mdc_wave_errs", 64'(mdc_bad), 64'd0);
    check("busy_errs", 64'(busy_bad), 64'd0);
    check("early_rsp_valid", 64'(rv_bad), 64'd0);
    check("ready_in_frame", 64'(rdy_bad), 64'd0);
    check("rsp_valid", 64'(o_rv), 64'd1);
    check("rsp_rdata", 64'(o_rdata), 64'(v.exp_rdata));
    check("rsp_err", 64'(o_err), 64'(v.exp_err));
    check("ready_at_rsp", 64'(o_ready), 64'd1);
    check("busy_at_rsp", 64'(o_busy), 64'd0);
    check("idle_lines", 64'({o_mdc, o_oe, o_out}), 64'(3'b001));
    if (v.hold) set_cmd(1'b1, nxt.op, nxt.prtad, nxt.devad, nxt.data);
    else        set_cmd(1'b0, ~v.op, ~v.prtad, ~v.devad, ~v.data);
  endtask

  task automatic run_vec(input int i);
    int acc;
    if (!(i > 0 && vecs[i-1].hold)) begin
      sel = vecs[i].sel;
      @(negedge PCLK);
      check("rsp_pulse_low", 64'(o_rv), 64'd0);
      set_cmd(1'b1, vecs[i].op, vecs[i].prtad, vecs[i].devad, vecs[i].data);
    end
    run_frame(vecs[i], vecs[(i < int'(NV) - 1) ? i + 1 : i], acc);
    if (i > 0 && vecs[i-1].hold)
      check("b2b_rsp_cycle", 64'(edge_cnt - prev_acc + 1), 64'd514);
    if (vecs[i].hold) prev_acc = acc;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    vecs[0] = mk(0, 2'b01, 5'h03, 5'h01, 16'hA5C3, 0, 16'h0000, 32'h1186A5C3, 32'hFFFFFFFF, 16'h0000, 0, 0);
    vecs[1] = mk(0, 2'b11, 5'h03, 5'h01, 16'hDEAD, 1, 16'h1234, 32'h3187FFFF, 32'hFFFC0000, 16'h1234, 0, 0);
    vecs[2] = mk(0, 2'b11, 5'h1F, 5'h1F, 16'h0000, 0, 16'h0000, 32'h3FFFFFFF, 32'hFFFC0000, 16'hFFFF, 1, 0);
    vecs[3] = mk(0, 2'b00, 5'h05, 5'h1E, 16'h0000, 0, 16'h0000, 32'h02FA0000, 32'hFFFFFFFF, 16'hFFFF, 0, 0);
    vecs[4] = mk(0, 2'b01, 5'h10, 5'h03, 16'h0F0F, 0, 16'h0000, 32'h180E0F0F, 32'hFFFFFFFF, 16'hFFFF, 0, 1);
    vecs[5] = mk(0, 2'b11, 5'h03, 5'h01, 16'h0000, 1, 16'hC001, 32'h3187FFFF, 32'hFFFC0000, 16'hC001, 0, 0);
    vecs[6] = mk(1, 2'b00, 5'h1F, 5'h0A, 16'h5A5A, 0, 16'h0000, 32'h0FAA5A5A, 32'hFFFFFFFF, 16'h0000, 0, 0);
    vecs[7] = mk(1, 2'b10, 5'h00, 5'h1F, 16'h0000, 1, 16'hBEEF, 32'h207FFFFF, 32'hFFFC0000, 16'hBEEF, 0, 0);

    // Reset values on both instances
    set_cmd(1'b0, 2'b00, 5'h00, 5'h00, 16'h0000);
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_ready0", 64'(bus0.cmd_ready), 64'd1);
    check("rst_busy0", 64'(busy0), 64'd0);
    check("rst_rv0", 64'(bus0.rsp_valid), 64'd0);
    check("rst_rdata0", 64'(bus0.rsp_rdata), 64'd0);
    check("rst_err0", 64'(bus0.rsp_err), 64'd0);
    check("rst_lines0", 64'({mdc0, oe0, out0}), 64'(3'b001));
    check("rst_ready1", 64'(bus1.cmd_ready), 64'd1);
    check("rst_lines1", 64'({mdc1, oe1, out1, busy1}), 64'(4'b0010));
    PRESETn = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset mid-frame: accept at edge 0, PRESETn low sampled at edge 100
    sel = 1'b0;
    @(negedge PCLK);
    set_cmd(1'b1, 2'b01, 5'h02, 5'h07, 16'h1357);
    @(posedge PCLK);
    #1;
    set_cmd(1'b0, 2'b00, 5'h00, 5'h00, 16'h0000);
    repeat (100) @(negedge PCLK);
    check("pre_abort_mdc", 64'(o_mdc), 64'd1);
    check("pre_abort_busy", 64'({o_busy, o_oe}), 64'(2'b11));
    PRESETn = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    check("abort_lines", 64'({o_mdc, o_oe, o_out}), 64'(3'b001));
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_no_rsp", 64'(o_rv), 64'd0);
    check("abort_ready", 64'(o_ready), 64'd1);
    check("abort_rdata", 64'(o_rdata), 64'd0);
    @(posedge PCLK);
    #1;
    set_cmd(1'b1, vecs[0].op, vecs[0].prtad, vecs[0].devad, vecs[0].data);
    @(negedge PCLK);
    check("abort_no_rsp_102", 64'(o_rv), 64'd0);
    run_frame(vecs[0], vecs[0], acc);

    for (int i = 6; i < int'(NV); i++) run_vec(i);

    @(negedge PCLK);
    check("final_rsp_pulse_low", 64'(o_rv), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
